// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that shares one fixed-latency memory port among NUM_REQ
// valid/ready requesters, with a single transaction in flight at a time.
module mem_port_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ-1:0]             req_we_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0][1:0]        req_width_i,
    input  logic [NUM_REQ-1:0]             req_sext_i,
    input  logic [NUM_REQ-1:0][31:0]       req_wdata_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic [31:0]                    rsp_rdata_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [1:0]                     mem_width_o,
    output logic                           mem_sext_o,
    output logic                           mem_we_o,
    output logic [31:0]                    mem_wdata_o,
    input  logic [31:0]                    mem_rdata_i
);
    // Width encoding shared with the memory: BYTE=0, HALF=1, WORD=2.
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q,  grant_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [1:0]        width_q,  width_d;
    logic              sext_q,   sext_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [31:0]       rdata_q,  rdata_d;

    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic [IDX_W-1:0]  next_rr;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        next_rr = IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (state_q == S_IDLE && grant_found) begin
            req_ready_o[grant_idx] = 1'b1;
        end
        if (state_q == S_RESP) begin
            rsp_valid_o[grant_q] = 1'b1;
        end
    end

    // Address/width/sext hold between transactions so the memory's data_o stays
    // stable; write enable and write data are only live during ISSUE.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        cmd_we_d = cmd_we_q;
        addr_d   = addr_q;
        width_d  = width_q;
        sext_d   = sext_q;
        mem_we_d = 1'b0;
        wdata_d  = '0;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d  = S_ISSUE;
                    rr_ptr_d = next_rr;
                    grant_d  = grant_idx;
                    cmd_we_d = req_we_i[grant_idx];
                    addr_d   = req_addr_i[grant_idx];
                    width_d  = req_width_i[grant_idx];
                    sext_d   = req_sext_i[grant_idx];
                    mem_we_d = req_we_i[grant_idx];
                    wdata_d  = req_wdata_i[grant_idx];
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = cmd_we_q ? 32'd0 : mem_rdata_i;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i[grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            cmd_we_q <= 1'b0;
            addr_q   <= '0;
            width_q  <= W_BYTE;
            sext_q   <= 1'b0;
            mem_we_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            cmd_we_q <= cmd_we_d;
            addr_q   <= addr_d;
            width_q  <= width_d;
            sext_q   <= sext_d;
            mem_we_q <= mem_we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_width_o = width_q;
    assign mem_sext_o  = sext_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_port_arbiter: a cycle table on a MEM_LATENCY=1 instance,
// plus hand sequences for MEM_LATENCY=3 and an asynchronous reset mid-transaction.
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic preload;

    // Instance with MEM_LATENCY=1
    logic                 rst1;
    logic [1:0]           v1, rdy1, we1, sx1, rspv1, rr1;
    logic [1:0][AW-1:0]   a1;
    logic [1:0][1:0]      w1;
    logic [1:0][31:0]     wd1;
    logic [31:0]          rd1, mrd1, mwd1;
    logic [AW-1:0]        ma1;
    logic [1:0]           mw1;
    logic                 ms1, mwe1;

    // Instance with MEM_LATENCY=3
    logic                 rst3;
    logic [1:0]           v3, rdy3, we3, sx3, rspv3, rr3;
    logic [1:0][AW-1:0]   a3;
    logic [1:0][1:0]      w3;
    logic [1:0][31:0]     wd3;
    logic [31:0]          rd3, mrd3, mwd3;
    logic [AW-1:0]        ma3;
    logic [1:0]           mw3;
    logic                 ms3, mwe3;

    mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .MEM_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst1),
        .req_valid_i(v1), .req_ready_o(rdy1), .req_we_i(we1), .req_addr_i(a1),
        .req_width_i(w1), .req_sext_i(sx1), .req_wdata_i(wd1),
        .rsp_valid_o(rspv1), .rsp_ready_i(rr1), .rsp_rdata_o(rd1),
        .mem_addr_o(ma1), .mem_width_o(mw1), .mem_sext_o(ms1), .mem_we_o(mwe1),
        .mem_wdata_o(mwd1), .mem_rdata_i(mrd1)
    );

    mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .MEM_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst3),
        .req_valid_i(v3), .req_ready_o(rdy3), .req_we_i(we3), .req_addr_i(a3),
        .req_width_i(w3), .req_sext_i(sx3), .req_wdata_i(wd3),
        .rsp_valid_o(rspv3), .rsp_ready_i(rr3), .rsp_rdata_o(rd3),
        .mem_addr_o(ma3), .mem_width_o(mw3), .mem_sext_o(ms3), .mem_we_o(mwe3),
        .mem_wdata_o(mwd3), .mem_rdata_i(mrd3)
    );

    function automatic logic [31:0] rd_fmt(input logic [31:0] raw, input logic [1:0] w,
                                           input logic s);
        case (w)
            W_BYTE:  return {{24{s & raw[7]}}, raw[7:0]};
            W_HALF:  return {{16{s & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Byte-addressed little-endian memory models; read data appears exactly
    // MEM_LATENCY cycles after the cycle the address was presented.
    logic [7:0]  mem1 [0:1023];
    logic [7:0]  mem3 [0:1023];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= 8'h00;
            mem1[4] <= 8'h44; mem1[5] <= 8'h33; mem1[6] <= 8'h22; mem1[7] <= 8'h11;
        end else if (mwe1) begin
            mem1[ma1] <= mwd1[7:0];
            if (mw1 != W_BYTE) mem1[ma1 + 10'd1] <= mwd1[15:8];
            if (mw1 == W_WORD) begin
                mem1[ma1 + 10'd2] <= mwd1[23:16];
                mem1[ma1 + 10'd3] <= mwd1[31:24];
            end
        end
        pipe1 <= rd_fmt({mem1[ma1 + 10'd3], mem1[ma1 + 10'd2], mem1[ma1 + 10'd1], mem1[ma1]},
                        mw1, ms1);
    end
    assign mrd1 = pipe1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem3[i] <= 8'h00;
            mem3[0] <= 8'hEF; mem3[1] <= 8'hBE; mem3[2] <= 8'hAD; mem3[3] <= 8'hDE;
            mem3[4] <= 8'h44; mem3[5] <= 8'h33; mem3[6] <= 8'h22; mem3[7] <= 8'h11;
        end else if (mwe3) begin
            mem3[ma3] <= mwd3[7:0];
            if (mw3 != W_BYTE) mem3[ma3 + 10'd1] <= mwd3[15:8];
            if (mw3 == W_WORD) begin
                mem3[ma3 + 10'd2] <= mwd3[23:16];
                mem3[ma3 + 10'd3] <= mwd3[31:24];
            end
        end
        pipe3[0] <= rd_fmt({mem3[ma3 + 10'd3], mem3[ma3 + 10'd2], mem3[ma3 + 10'd1], mem3[ma3]},
                           mw3, ms3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mrd3 = pipe3[2];

    typedef struct {
        logic [1:0]    v, we, sx, rr;
        logic [AW-1:0] a0, a1;
        logic [1:0]    w0, w1;
        logic [31:0]   wd1;
        logic [1:0]    e_rdy, e_rspv;
        logic          c_rd;
        logic [31:0]   e_rd;
        logic          e_mwe;
        logic [AW-1:0] e_ma;
        logic [31:0]   e_mwd;
    } vec_t;

    vec_t vq[$];

    logic [AW-1:0] cur_a0, cur_a1;
    logic [1:0]    cur_w0, cur_w1, cur_sx;
    logic [31:0]   cur_wd1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic add(input logic [1:0] v, input logic [1:0] we, input logic [1:0] rr,
                       input logic [1:0] e_rdy, input logic [1:0] e_rspv, input logic c_rd,
                       input logic [31:0] e_rd, input logic e_mwe, input logic [AW-1:0] e_ma,
                       input logic [31:0] e_mwd);
        vec_t t;
        t.v = v; t.we = we; t.sx = cur_sx; t.rr = rr;
        t.a0 = cur_a0; t.a1 = cur_a1; t.w0 = cur_w0; t.w1 = cur_w1; t.wd1 = cur_wd1;
        t.e_rdy = e_rdy; t.e_rspv = e_rspv; t.c_rd = c_rd; t.e_rd = e_rd;
        t.e_mwe = e_mwe; t.e_ma = e_ma; t.e_mwd = e_mwd;
        vq.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset1(input string tag);
        check({tag, " req_ready"}, {30'd0, rdy1}, 32'd0);
        check({tag, " rsp_valid"}, {30'd0, rspv1}, 32'd0);
        check({tag, " rsp_rdata"}, rd1, 32'd0);
        check({tag, " mem_addr"}, {22'd0, ma1}, 32'd0);
        check({tag, " mem_width"}, {30'd0, mw1}, {30'd0, W_BYTE});
        check({tag, " mem_sext"}, {31'd0, ms1}, 32'd0);
        check({tag, " mem_we"}, {31'd0, mwe1}, 32'd0);
        check({tag, " mem_wdata"}, mwd1, 32'd0);
    endtask

    initial begin
        logic got;
        rst1 = 1'b1; rst3 = 1'b1; preload = 1'b1;
        v1 = '0; we1 = '0; sx1 = '0; rr1 = '0; a1 = '0; w1 = '0; wd1 = '0;
        v3 = '0; we3 = '0; sx3 = '0; rr3 = '0; a3 = '0; w3 = '0; wd3 = '0;

        // Single read of 0x004, then req1 WORD write and BYTE read-back
        cur_a0 = 10'h004; cur_w0 = W_WORD; cur_a1 = '0; cur_w1 = W_BYTE;
        cur_sx = 2'b00; cur_wd1 = '0;
        add(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 32'd0,         1'b0, 10'h000, 32'd0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h004, 32'd0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h004, 32'd0);
        add(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 1'b1, 32'h11223344,  1'b0, 10'h004, 32'd0);
        cur_a1 = 10'h010; cur_w1 = W_WORD; cur_wd1 = 32'h0DEFACED;
        add(2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 32'd0,         1'b0, 10'h004, 32'd0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b1, 10'h010, 32'h0DEFACED);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h010, 32'd0);
        add(2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 1'b1, 32'd0,         1'b0, 10'h010, 32'd0);
        cur_a1 = 10'h011; cur_w1 = W_BYTE; cur_wd1 = '0;
        add(2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 32'd0,         1'b0, 10'h010, 32'd0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h011, 32'd0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h011, 32'd0);
        add(2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 1'b1, 32'h000000AC,  1'b0, 10'h011, 32'd0);
        // Contention with early/foreign rsp_ready: grants 0,1,0,1
        cur_a0 = 10'h004; cur_w0 = W_WORD; cur_a1 = 10'h010; cur_w1 = W_WORD;
        for (int t = 0; t < 2; t++) begin
            add(2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0, 32'd0, 1'b0, (t == 0) ? 10'h011 : 10'h010, 32'd0);
            add(2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 32'd0,        1'b0, 10'h004, 32'd0);
            add(2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 32'd0,        1'b0, 10'h004, 32'd0);
            add(2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 32'h11223344, 1'b0, 10'h004, 32'd0);
            add(2'b11, 2'b00, 2'b11, 2'b10, 2'b00, 1'b0, 32'd0,        1'b0, 10'h004, 32'd0);
            add(2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 32'd0,        1'b0, 10'h010, 32'd0);
            add(2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 32'd0,        1'b0, 10'h010, 32'd0);
            add(2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 1'b1, 32'h0DEFACED, 1'b0, 10'h010, 32'd0);
        end
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h010, 32'd0);
        // Response backpressure on req0 while req1 waits; req1 sign-extended byte read
        cur_a1 = 10'h011; cur_w1 = W_BYTE; cur_sx = 2'b10;
        add(2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 32'd0,         1'b0, 10'h010, 32'd0);
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h004, 32'd0);
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h004, 32'd0);
        for (int t = 0; t < 5; t++)
            add(2'b11, 2'b00, (t == 2) ? 2'b10 : 2'b00, 2'b00, 2'b01, 1'b1, 32'h11223344,
                1'b0, 10'h004, 32'd0);
        add(2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 1'b1, 32'h11223344,  1'b0, 10'h004, 32'd0);
        add(2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 32'd0,         1'b0, 10'h004, 32'd0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h011, 32'd0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h011, 32'd0);
        add(2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 1'b1, 32'hFFFFFFAC,  1'b0, 10'h011, 32'd0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0,         1'b0, 10'h011, 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
        #1;
        check_reset1("reset");
        check("reset dut3 rsp_valid", {30'd0, rspv3}, 32'd0);

        foreach (vq[i]) begin
            v1 = vq[i].v; we1 = vq[i].we; sx1 = vq[i].sx; rr1 = vq[i].rr;
            a1[0] = vq[i].a0; a1[1] = vq[i].a1; w1[0] = vq[i].w0; w1[1] = vq[i].w1;
            wd1[0] = '0; wd1[1] = vq[i].wd1;
            #1;
            check($sformatf("c%0d req_ready", i), {30'd0, rdy1}, {30'd0, vq[i].e_rdy});
            check($sformatf("c%0d rsp_valid", i), {30'd0, rspv1}, {30'd0, vq[i].e_rspv});
            if (vq[i].c_rd) check($sformatf("c%0d rsp_rdata", i), rd1, vq[i].e_rd);
            check($sformatf("c%0d mem_we", i), {31'd0, mwe1}, {31'd0, vq[i].e_mwe});
            check($sformatf("c%0d mem_addr", i), {22'd0, ma1}, {22'd0, vq[i].e_ma});
            check($sformatf("c%0d mem_wdata", i), mwd1, vq[i].e_mwd);
            @(negedge clk);
        end
        v1 = '0; rr1 = '0; we1 = '0; sx1 = '0;

        // MEM_LATENCY=3: accept at cycle 0, response at cycle 5
        v3 = 2'b01; a3[0] = 10'h004; w3[0] = W_WORD; rr3 = 2'b01;
        #1;
        check("lat3 c0 req_ready", {30'd0, rdy3}, 32'd1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            v3 = '0;
            #1;
            check($sformatf("lat3 c%0d rsp_valid", c), {30'd0, rspv3}, (c == 5) ? 32'd1 : 32'd0);
            if (c == 4) check("lat3 c4 rdata not yet captured", rd3, 32'd0);
            if (c == 5) check("lat3 c5 rsp_rdata", rd3, 32'h11223344);
        end

        // Asynchronous reset while dut1 is in WAIT
        @(negedge clk);
        v1 = 2'b01; a1[0] = 10'h004; w1[0] = W_WORD; rr1 = 2'b01;
        @(negedge clk);
        v1 = 2'b00;
        @(posedge clk);
        #2;
        rst1 = 1'b1;
        #1;
        check_reset1("async reset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("in reset c%0d rsp_valid", c), {30'd0, rspv1}, 32'd0);
        end
        rst1 = 1'b0;
        v1 = 2'b11;
        #1;
        check("post-reset grant rr_ptr=0", {30'd0, rdy1}, 32'd1);
        @(negedge clk);
        v1 = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            #1;
            if (rspv1 == 2'b01) got = 1'b1;
        end
        check("post-reset rsp arrives", {31'd0, got}, 32'd1);
        check("post-reset rsp_rdata", rd1, 32'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
